// File: rtl/cfg_lut_k.sv
// rtl/cfg_lut_k.sv - K-input LUT cell with serial config chain and optional output FF (option macro: CFG_PARITY_EN)
module cfg_lut_k #(
   parameter int K = 4,
`ifdef CFG_PARITY_EN
   localparam int L = (2**K) + 2,
`else
   localparam int L = (2**K) + 1,
`endif
   parameter logic [L-1:0] INIT = '0
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic [K-1:0] A,
   input  logic         CE,
   input  logic         CFG_EN,
   input  logic         CFG_DIN,
   output logic         CFG_DOUT,
   output logic         CFG_DONE,
   output logic         CFG_ERR,
   output logic         OUT
);

   localparam int T  = 2**K;
   localparam int CW = $clog2(L + 1);
   localparam logic [CW-1:0] C_FULL = CW'(L);

   logic [L-1:0]  r_cfg_sr;
   logic [CW-1:0] r_cnt;
   logic          r_cfg_en_q;
   logic          r_q;

   logic [L-1:0]  w_sr_next;
   logic [T-1:0]  w_table;
   logic          w_reg_mode;
   logic          w_lut;
   logic          w_en_rise;
   logic          w_full;
   logic          w_err;

   assign w_sr_next  = CFG_EN ? {r_cfg_sr[L-2:0], CFG_DIN} : r_cfg_sr;
   assign w_table    = r_cfg_sr[T-1:0];
   assign w_reg_mode = r_cfg_sr[T];
   assign w_lut      = w_table[A];
   assign w_en_rise  = CFG_EN && !r_cfg_en_q;
   assign w_full     = (r_cnt == C_FULL);

   // Config shift register; bits past a full frame keep flowing out to the next cell
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cfg_sr <= INIT;
      end else begin
         r_cfg_sr <= w_sr_next;
      end
   end

   // Bit counter: restarts at 1 on each new frame, saturates once a full frame is in
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt      <= C_FULL;
         r_cfg_en_q <= 1'b0;
      end else begin
         r_cfg_en_q <= CFG_EN;
         if (w_en_rise) begin
            r_cnt <= CW'(1);
         end else if (CFG_EN && !w_full) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Output FF: held clear while configuring so stale table data never escapes
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_q <= 1'b0;
      end else if (CFG_EN) begin
         r_q <= 1'b0;
      end else if (w_reg_mode && CE) begin
         r_q <= w_lut;
      end
   end

`ifdef CFG_PARITY_EN
   logic r_err;

   // Parity flag captured on the cycle the frame completes, cleared when a new frame starts
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_err <= ^INIT;
      end else if (w_en_rise) begin
         r_err <= 1'b0;
      end else if (CFG_EN && !w_full && (r_cnt + CW'(1) == C_FULL)) begin
         r_err <= ^w_sr_next;
      end
   end

   assign w_err = r_err;
`else
   assign w_err = 1'b0;
`endif

   assign CFG_DOUT = r_cfg_sr[L-1];
   assign CFG_DONE = w_full && !CFG_EN;
   assign CFG_ERR  = w_err;
   assign OUT      = (CFG_EN || !w_full || w_err) ? 1'b0 : (w_reg_mode ? r_q : w_lut);

endmodule

// File: tb/tb_cfg_lut_k.sv
// tb/tb_cfg_lut_k.sv - scoreboard bench for cfg_lut_k (single cell and two-cell chain)
module tb_cfg_lut_k;

`ifdef CFG_PARITY_EN
   localparam int L = 18;
`else
   localparam int L = 17;
`endif

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [3:0] A;
   logic       CE;
   logic       CFG_EN;
   logic       CFG_DIN;
   logic       w_chain;
   logic       dout1, done0, done1, err0, err1, out0, out1;

   always #5 CLK = ~CLK;

   cfg_lut_k #(.K(4)) u0 (
      .CLK(CLK), .RST_N(RST_N), .A(A), .CE(CE), .CFG_EN(CFG_EN), .CFG_DIN(CFG_DIN),
      .CFG_DOUT(w_chain), .CFG_DONE(done0), .CFG_ERR(err0), .OUT(out0)
   );

   cfg_lut_k #(.K(4)) u1 (
      .CLK(CLK), .RST_N(RST_N), .A(A), .CE(CE), .CFG_EN(CFG_EN), .CFG_DIN(w_chain),
      .CFG_DOUT(dout1), .CFG_DONE(done1), .CFG_ERR(err1), .OUT(out1)
   );

   localparam int S_OUT0 = 0, S_DONE0 = 1, S_ERR0 = 2, S_DOUT0 = 3, S_OUT1 = 4, S_DONE1 = 5;

   typedef struct {
      int   sel;
      logic exp;
      int   tag;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   tag_n  = 0;

   function automatic logic actual(input int sel);
      case (sel)
         S_OUT0:  return out0;
         S_DONE0: return done0;
         S_ERR0:  return err0;
         S_DOUT0: return w_chain;
         S_OUT1:  return out1;
         default: return done1;
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         S_OUT0:  return "out0";
         S_DONE0: return "done0";
         S_ERR0:  return "err0";
         S_DOUT0: return "dout0";
         S_OUT1:  return "out1";
         default: return "done1";
      endcase
   endfunction

   // Monitor: compares every queued expectation against the DUT at the falling edge
   always @(negedge CLK) begin
      while (sbq.size() > 0) begin
         exp_t e;
         logic a;
         e = sbq.pop_front();
         a = actual(e.sel);
         checks++;
         if (a !== e.exp) begin
            errors++;
            $display("FAIL %s #%0d: got %b, want %b", sel_name(e.sel), e.tag, a, e.exp);
         end
      end
   end

   task automatic push_exp(input int sel, input logic v);
      sbq.push_back('{sel, v, tag_n});
      tag_n++;
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   // Frame in cfg_sr layout; bit L-1 is transmitted first
   function automatic logic [L-1:0] mkframe(input logic mode, input logic [15:0] tbl);
      logic [L-1:0] f;
      f        = '0;
      f[15:0]  = tbl;
      f[16]    = mode;
`ifdef CFG_PARITY_EN
      f[17]    = ^{mode, tbl};
`endif
      return f;
   endfunction

   task automatic shift_bits(input logic [L-1:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         CFG_EN  = 1'b1;
         CFG_DIN = f[L-1-i];
         step;
      end
   endtask

   task automatic end_shift;
      CFG_EN  = 1'b0;
      CFG_DIN = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [L-1:0] f_xor, f_xor_r, f_and, f_or;
      f_xor   = mkframe(1'b0, 16'h6996);
      f_xor_r = mkframe(1'b1, 16'h6996);
      f_and   = mkframe(1'b0, 16'h8000);
      f_or    = mkframe(1'b0, 16'hFFFE);

      RST_N = 1'b0; A = 4'd0; CE = 1'b0; CFG_EN = 1'b0; CFG_DIN = 1'b0;
      step; step;
      RST_N = 1'b1;
      step;

      // Reset state across every select value
      for (int a = 0; a < 16; a++) begin
         A = 4'(a);
         push_exp(S_OUT0, 1'b0);
         push_exp(S_DONE0, 1'b1);
         push_exp(S_ERR0, 1'b0);
         push_exp(S_DOUT0, 1'b0);
         step;
      end

      // Combinational XOR4
      shift_bits(f_xor, L);
      end_shift;
      push_exp(S_DONE0, 1'b1);
      push_exp(S_ERR0, 1'b0);
      for (int a = 0; a < 16; a++) begin
         A = 4'(a);
         push_exp(S_OUT0, ^(4'(a)));
         step;
      end

      // Registered XOR4: one-cycle latency, CE hold
      shift_bits(f_xor_r, L);
      end_shift;
      CE = 1'b1; A = 4'd0;
      push_exp(S_OUT0, 1'b0);
      step;
      A = 4'b0111;
      push_exp(S_OUT0, 1'b0);
      step;
      push_exp(S_OUT0, 1'b1);
      CE = 1'b0; A = 4'd0;
      step;
      push_exp(S_OUT0, 1'b1);
      A = 4'd3;
      step;
      push_exp(S_OUT0, 1'b1);
      CE = 1'b1; A = 4'd0;
      step;
      push_exp(S_OUT0, 1'b0);
      step;
      CE = 1'b0;

      // Reset in the middle of a frame, then reload
      shift_bits(f_xor, 9);
      RST_N = 1'b0;
      CFG_EN = 1'b0;
      CFG_DIN = 1'b0;
      A = 4'd1;
      #1;
      push_exp(S_OUT0, 1'b0);
      push_exp(S_DONE0, 1'b1);
      push_exp(S_DOUT0, 1'b0);
      step;
      RST_N = 1'b1;
      step;
      shift_bits(f_xor, L);
      end_shift;
      A = 4'd3;  push_exp(S_OUT0, 1'b0); step;
      A = 4'd1;  push_exp(S_OUT0, 1'b1); step;
      A = 4'd14; push_exp(S_OUT0, 1'b1); step;
      A = 4'd15; push_exp(S_OUT0, 1'b0); step;

      // Two-cell chain: first frame ends up downstream
      shift_bits(f_and, L);
      shift_bits(f_or, L);
      end_shift;
      push_exp(S_DONE0, 1'b1);
      push_exp(S_DONE1, 1'b1);
      A = 4'd15; push_exp(S_OUT0, 1'b1); push_exp(S_OUT1, 1'b1); step;
      A = 4'd0;  push_exp(S_OUT0, 1'b0); push_exp(S_OUT1, 1'b0); step;
      A = 4'd5;  push_exp(S_OUT0, 1'b1); push_exp(S_OUT1, 1'b0); step;

      // Aborted frame
      shift_bits(f_or, 10);
      end_shift;
      A = 4'd15;
      push_exp(S_DONE0, 1'b0);
      push_exp(S_DONE1, 1'b0);
      push_exp(S_OUT0, 1'b0);
      push_exp(S_OUT1, 1'b0);
      step;

`ifdef CFG_PARITY_EN
      // Bad then good parity
      begin
         logic [L-1:0] f_bad;
         f_bad = f_xor;
         f_bad[L-1] = ~f_bad[L-1];
         shift_bits(f_bad, L);
         end_shift;
         A = 4'd1;
         push_exp(S_DONE0, 1'b1);
         push_exp(S_ERR0, 1'b1);
         push_exp(S_OUT0, 1'b0);
         step;
         shift_bits(f_xor, L);
         end_shift;
         push_exp(S_ERR0, 1'b0);
         push_exp(S_OUT0, 1'b1);
         step;
      end
`endif

      for (int i = 0; i < 10 && sbq.size() > 0; i++) step;
      if (sbq.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
